seq_multiplier: RTL and testbench

//   Parametrised sequential shift-add multiplier; next generation of the lab

---
 rtl/seq_multiplier_pkg.sv | 11 +
 rtl/seq_multiplier_datapath.sv | 71 +++++++
 rtl/seq_multiplier.sv | 95 +++++++++
 tb/tb_seq_multiplier.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential multiplier family.
package seq_multiplier_pkg;

  // Controller states, shared with the booth and pipelined variants
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mult_state_t;

endpackage

// File: rtl/seq_multiplier_datapath.sv
// Shift-add datapath: operand magnitude capture, accumulator, final sign fix.
module seq_mult_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [CNT_W-1:0]   cnt,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               neg_flag;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] wide_mcand;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] product_nxt;

  // Operand magnitudes and the next accumulator / final result values
  always_comb begin
    a_neg       = signed_mode & a[WIDTH-1];
    b_neg       = signed_mode & b[WIDTH-1];
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    wide_mcand  = {{WIDTH{1'b0}}, mcand};
    addend      = mplier[0] ? (wide_mcand << cnt) : '0;
    acc_nxt     = acc + addend;
    // Result is taken from the post-step accumulator so the last step and
    // the product update share one edge
    product_nxt = neg_flag ? -acc_nxt : acc_nxt;
  end

  // Operand capture, per-cycle accumulate/shift, and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      neg_flag <= 1'b0;
      product  <= '0;
    end else begin
      if (load) begin
        mcand    <= a_mag;
        mplier   <= b_mag;
        neg_flag <= a_neg ^ b_neg;
        acc      <= '0;
      end else if (step) begin
        acc    <= acc_nxt;
        mplier <= mplier >> 1;
      end
      if (finish) begin
        product <= product_nxt;
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock,
// unsigned or two's-complement operands, start/done handshake.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mult_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             step;
  logic             last;
  logic             finish;

  // Handshake decode shared by the controller and the datapath
  always_comb begin
    accept = start && ((state == ST_IDLE) || (state == ST_FIN));
    step   = (state == ST_RUN);
    last   = (cnt == CNT_W'(WIDTH - 1));
    finish = step && last;
  end

  // Controller: WIDTH RUN cycles per operation, FIN lasts one cycle and may
  // accept the next operation directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            state <= ST_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_FIN: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  seq_mult_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept),
    .step        (step),
    .finish      (finish),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .cnt         (cnt),
    .product     (product)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a WIDTH=4 and a WIDTH=8 instance, table vectors,
// directed multi-cycle sequences and random operands against an arithmetic model.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  product4;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4));

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiplication of the operands' numeric values
  function automatic logic [15:0] model(input int w, input bit sm,
                                        input logic [7:0] a, input logic [7:0] b);
    longint x, y, p;
    x = (w == 4) ? longint'(a[3:0]) : longint'(a);
    y = (w == 4) ? longint'(b[3:0]) : longint'(b);
    if (sm && x >= (64'sd1 << (w - 1))) x = x - (64'sd1 << w);
    if (sm && y >= (64'sd1 << (w - 1))) y = y - (64'sd1 << w);
    p = x * y;
    if (w == 4) return {8'h00, p[7:0]};
    return p[15:0];
  endfunction

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic [15:0] get_prod(input int w);
    return (w == 4) ? {8'h00, product4} : product8;
  endfunction

  task automatic drive(input int w, input logic st, input bit sm,
                       input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      start4 = st; sm4 = sm; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = st; sm8 = sm; a8 = a; b8 = b;
    end
  endtask

  // One isolated operation: done must be seen w edges after the accepting edge
  // (i.e. captured high by the (w+1)th edge), previous product held until then.
  task automatic run_op(input int w, input bit sm, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp, input string name);
    logic [15:0] prev;
    int edges;
    bit held_ok, busy_ok;
    prev = get_prod(w);
    held_ok = 1'b1;
    busy_ok = 1'b1;
    @(negedge clk);
    drive(w, 1'b1, sm, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, sm, a, b);
    edges = 0;
    while (!get_done(w) && edges < 40) begin
      if (get_prod(w) !== prev) held_ok = 1'b0;
      if (get_busy(w) !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    chk({name, " latency"}, edges, w);
    chk({name, " product"}, get_prod(w), exp);
    chk({name, " held"}, held_ok, 1'b1);
    chk({name, " busy"}, {busy_ok, get_busy(w)}, 2'b10);
    @(negedge clk);
    chk({name, " pulse"}, {get_done(w), get_prod(w)}, {1'b0, exp});
  endtask

  typedef struct {
    bit         sm;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [15:0] prev;
    int edges, gap;
    bit ok, extra;

    tbl[0] = '{1'b0, 4'd15,    4'd15,    8'd225,  "u15x15"};
    tbl[1] = '{1'b1, 4'b1000,  4'b1000,  8'd64,   "s-8x-8"};
    tbl[2] = '{1'b1, 4'b1101,  4'd5,     8'hF1,   "s-3x5"};
    tbl[3] = '{1'b1, 4'd0,     4'b1000,  8'd0,    "s0x-8"};
    tbl[4] = '{1'b0, 4'b1000,  4'b1000,  8'd64,   "u8x8"};
    tbl[5] = '{1'b1, 4'b1000,  4'd7,     8'hC8,   "s-8x7"};
    tbl[6] = '{1'b1, 4'b1111,  4'b1111,  8'd1,    "s-1x-1"};

    #1;
    chk("reset4", {busy4, done4, product4}, '0);
    chk("reset8", {busy8, done8, product8}, '0);
    #13 rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(4, tbl[i].sm, {4'h0, tbl[i].a}, {4'h0, tbl[i].b}, {8'h00, tbl[i].exp}, tbl[i].name);

    // Back-to-back with start held through FIN
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 8'd200, 8'd3);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 8'd7, 8'd9);
    ok = 1'b1;
    edges = 0;
    while (!done8 && edges < 40) begin
      if (busy8 !== 1'b1) ok = 1'b0;
      @(posedge clk); @(negedge clk); edges++;
    end
    chk("b2b first latency", edges, 8);
    chk("b2b first product", product8, 16'd600);
    chk("b2b busy in FIN", busy8, 1'b0);
    gap = 0;
    @(posedge clk); @(negedge clk); gap++;
    while (!done8 && gap < 40) begin
      if (busy8 !== 1'b1) ok = 1'b0;
      @(posedge clk); @(negedge clk); gap++;
    end
    drive(8, 1'b0, 1'b0, 8'd7, 8'd9);
    chk("b2b done spacing", gap, 9);
    chk("b2b second product", product8, 16'd63);
    chk("b2b busy high in RUN", ok, 1'b1);
    @(negedge clk);
    chk("b2b idle after", {busy8, done8}, 2'b00);

    // Start pulses and operand changes while busy are ignored
    prev = product8;
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 8'd12, 8'd12);
    @(posedge clk); @(negedge clk);
    drive(8, 1'b0, 1'b1, 8'd12, 8'd12);
    ok = 1'b1;
    edges = 0;
    while (!done8 && edges < 40) begin
      if (product8 !== prev) ok = 1'b0;
      if (edges == 2 || edges == 5) drive(8, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
      else drive(8, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
      @(posedge clk); @(negedge clk); edges++;
    end
    drive(8, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("busy-start latency", edges, 8);
    chk("busy-start product", product8, 16'd144);
    chk("busy-start held", ok, 1'b1);
    extra = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) extra = 1'b1;
    end
    chk("busy-start single done", extra, 1'b0);

    // Reset in the middle of RUN
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 8'd50, 8'd5);
    @(posedge clk); @(negedge clk);
    drive(8, 1'b0, 1'b0, 8'd50, 8'd5);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun reset outputs", {busy8, done8, product8}, '0);
    #4 rst_n = 1'b1;
    extra = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) extra = 1'b1;
    end
    chk("midrun no done", extra, 1'b0);
    run_op(8, 1'b0, 8'd50, 8'd5, 16'd250, "after reset");

    // Exhaustive WIDTH=4, both modes
    for (int sm = 0; sm < 2; sm++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run_op(4, sm[0], 8'(a), 8'(b), model(4, sm[0], 8'(a), 8'(b)), "ex4");

    // Random WIDTH=8, plus the most-negative corner
    run_op(8, 1'b1, 8'h80, 8'h80, 16'h4000, "s8 -128x-128");
    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra, rb;
      bit rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      run_op(8, rs, ra, rb, model(8, rs, ra, rb), "rnd8");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
